// File: rtl/nexus_flow_pkg.sv
// Shared types and constants for the frame-interpolation block.
package nexus_flow_pkg;

  typedef enum logic [1:0] {
    MODE_BLEND   = 2'd0,
    MODE_PASS_A  = 2'd1,
    MODE_PASS_B  = 2'd2,
    MODE_ABSDIFF = 2'd3
  } mode_e;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_FINISH = 2'd2
  } state_e;

  // Blend rounds to nearest: (a*(256-w) + b*w + 128) >> 8.
  localparam int unsigned ROUND_C      = 128;
  localparam int unsigned WEIGHT_SCALE = 256;

endpackage

// File: rtl/nexus_flow_fifo.sv
// First-word-fall-through synchronous FIFO with an occupancy count.
// The head entry is visible on rd_data whenever empty is low.
module nexus_flow_fifo #(
  parameter int WIDTH = 33,
  parameter int DEPTH = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       wr_en,
  input  logic [WIDTH-1:0]           wr_data,
  input  logic                       rd_en,
  output logic [WIDTH-1:0]           rd_data,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             full;
  logic             wr_ok;
  logic             rd_ok;

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign wr_ok   = wr_en && !full;
  assign rd_ok   = rd_en && !empty;
  assign rd_data = mem[rd_ptr];

  // Storage write port.
  // NOTE: the storage array has no reset; only pointers and count are reset, so
  // stale contents are never observable and the array can map to plain RAM.
  always_ff @(posedge clk) begin
    if (wr_ok) mem[wr_ptr] <= wr_data;
  end

  // Pointer and occupancy bookkeeping; a simultaneous read and write keeps count.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_ok) wr_ptr <= wr_ptr + AW'(1);
      if (rd_ok) rd_ptr <= rd_ptr + AW'(1);
      case ({wr_ok, rd_ok})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/nexus_flow_interp.sv
// Joins previous-frame (A) and current-frame (B) pixel streams and emits one
// interpolated stream: blend, pass-through or absolute-difference motion map.
// Two pipeline stages feed a credit-protected FWFT FIFO; the last beat of each
// frame is tagged.
module nexus_flow_interp
  import nexus_flow_pkg::*;
#(
  parameter int LANES       = 4,
  parameter int PIX_W       = 8,
  parameter int FRAME_BEATS = 1024,
  parameter int DEPTH       = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   enable,
  input  logic [1:0]             cfg_mode,
  input  logic [7:0]             cfg_weight,
  input  logic                   a_valid,
  output logic                   a_ready,
  input  logic [LANES*PIX_W-1:0] a_data,
  input  logic                   b_valid,
  output logic                   b_ready,
  input  logic [LANES*PIX_W-1:0] b_data,
  output logic                   o_valid,
  input  logic                   o_ready,
  output logic [LANES*PIX_W-1:0] o_data,
  output logic                   o_last,
  output logic                   frame_done,
  output logic [15:0]            frame_count,
  output logic                   busy
);

  localparam int DW     = LANES * PIX_W;
  localparam int PROD_W = PIX_W + 9;
  localparam int CNT_W  = $clog2(FRAME_BEATS);
  localparam int CW     = $clog2(DEPTH) + 1;
  localparam int SHIFT  = $clog2(WEIGHT_SCALE);
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(FRAME_BEATS - 1);

  state_e              state;
  logic [CNT_W-1:0]    beat_cnt;
  logic [CNT_W-1:0]    beat_nxt;
  logic                beat_last;
  mode_e               cfg_mode_q;
  logic [7:0]          cfg_weight_q;
  mode_e               mode_eff;
  logic [7:0]          weight_eff;
  logic                accept_ok;
  logic                fire;
  logic [1:0]          inflight;

  logic                s1_valid, s1_last, s2_valid, s2_last;
  mode_e               s1_mode;
  logic [LANES*PROD_W-1:0] lane_pa, lane_pb, s1_pa, s1_pb;
  logic [DW-1:0]       lane_diff, s1_a, s1_b, s1_diff;
  logic [DW-1:0]       lane_res, s2_data;

  logic [CW-1:0]       fifo_count;
  logic                fifo_empty;
  logic [DW:0]         fifo_rd_data;

  // Credit: everything already in the pipeline must still fit in the FIFO.
  assign inflight  = {1'b0, s1_valid} + {1'b0, s2_valid};
  assign accept_ok = (state == ST_RUN || state == ST_FINISH) &&
                     ((int'(fifo_count) + int'(inflight)) < DEPTH);
  assign a_ready   = accept_ok;
  assign b_ready   = accept_ok;
  assign fire      = accept_ok && a_valid && b_valid;

  assign beat_last = (beat_cnt == LAST_BEAT);
  assign beat_nxt  = fire ? (beat_last ? '0 : beat_cnt + CNT_W'(1)) : beat_cnt;

  // The first beat of a frame uses the live config; later beats use the latch.
  assign mode_eff   = (beat_cnt == '0) ? mode_e'(cfg_mode) : cfg_mode_q;
  assign weight_eff = (beat_cnt == '0) ? cfg_weight : cfg_weight_q;

  // Run-control state machine; a stop request lets the current frame finish.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      case (state)
        ST_IDLE:   if (enable) state <= ST_RUN;
        ST_RUN:    if (!enable) state <= (beat_nxt != '0) ? ST_FINISH : ST_IDLE;
        ST_FINISH: begin
          if (fire && beat_last) state <= ST_IDLE;
          else if (enable)       state <= (beat_cnt == '0) ? ST_IDLE : ST_RUN;
        end
        default:   state <= ST_IDLE;
      endcase
    end
  end

  // Beat position within the frame and per-frame config capture.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      beat_cnt     <= '0;
      cfg_mode_q   <= MODE_BLEND;
      cfg_weight_q <= '0;
    end else begin
      beat_cnt <= beat_nxt;
      if (fire && beat_cnt == '0) begin
        cfg_mode_q   <= mode_e'(cfg_mode);
        cfg_weight_q <= cfg_weight;
      end
    end
  end

  // Per-lane arithmetic: stage-1 products/diff, stage-2 round and mode select.
  for (genvar l = 0; l < LANES; l++) begin : g_lane
    logic [PIX_W-1:0]  a_pix, b_pix, s1a_pix, s1b_pix, s1d_pix, res;
    logic [PROD_W-1:0] sum;

    assign a_pix   = a_data[l*PIX_W +: PIX_W];
    assign b_pix   = b_data[l*PIX_W +: PIX_W];
    assign lane_pa[l*PROD_W +: PROD_W] = PROD_W'(a_pix) *
                                         (PROD_W'(WEIGHT_SCALE) - PROD_W'(weight_eff));
    assign lane_pb[l*PROD_W +: PROD_W] = PROD_W'(b_pix) * PROD_W'(weight_eff);
    assign lane_diff[l*PIX_W +: PIX_W] = (a_pix >= b_pix) ? (a_pix - b_pix) : (b_pix - a_pix);

    assign s1a_pix = s1_a[l*PIX_W +: PIX_W];
    assign s1b_pix = s1_b[l*PIX_W +: PIX_W];
    assign s1d_pix = s1_diff[l*PIX_W +: PIX_W];
    assign sum     = s1_pa[l*PROD_W +: PROD_W] + s1_pb[l*PROD_W +: PROD_W] + PROD_W'(ROUND_C);

    // Select the lane result for the latched mode.
    always_comb begin
      // NOTE: res gets a default before the case so no path leaves it unassigned,
      // which would otherwise infer a latch.
      res = s1a_pix;
      case (s1_mode)
        MODE_BLEND:   res = PIX_W'(sum >> SHIFT);
        MODE_PASS_A:  res = s1a_pix;
        MODE_PASS_B:  res = s1b_pix;
        MODE_ABSDIFF: res = s1d_pix;
        default:      res = s1a_pix;
      endcase
    end

    assign lane_res[l*PIX_W +: PIX_W] = res;
  end

  // Pipeline control: valid, last and mode travel with each beat; reset drops them.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_last  <= 1'b0;
      s1_mode  <= MODE_BLEND;
      s2_valid <= 1'b0;
      s2_last  <= 1'b0;
    end else begin
      s1_valid <= fire;
      s1_last  <= fire && beat_last;
      s1_mode  <= mode_eff;
      s2_valid <= s1_valid;
      s2_last  <= s1_valid && s1_last;
    end
  end

  // Pipeline data; qualified by the valid bits, so it captures every cycle.
  always_ff @(posedge clk) begin
    s1_pa   <= lane_pa;
    s1_pb   <= lane_pb;
    s1_a    <= a_data;
    s1_b    <= b_data;
    s1_diff <= lane_diff;
    s2_data <= lane_res;
  end

  // Frame completion is counted when the tagged beat enters the FIFO.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      frame_done  <= 1'b0;
      frame_count <= '0;
    end else begin
      frame_done <= s2_valid && s2_last;
      if (s2_valid && s2_last) frame_count <= frame_count + 16'd1;
    end
  end

  nexus_flow_fifo #(
    .WIDTH (DW + 1),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (s2_valid),
    .wr_data ({s2_last, s2_data}),
    .rd_en   (o_valid && o_ready),
    .rd_data (fifo_rd_data),
    .empty   (fifo_empty),
    .count   (fifo_count)
  );

  assign o_valid = !fifo_empty;
  assign o_data  = fifo_empty ? '0 : fifo_rd_data[DW-1:0];
  assign o_last  = fifo_empty ? 1'b0 : fifo_rd_data[DW];
  assign busy    = (state != ST_IDLE) || s1_valid || s2_valid || !fifo_empty;

endmodule
